// File: rtl/pc_flag_unit_pkg.sv
// Shared definitions for the program-counter / condition-flag stage.
//   cond_t     : branch condition encoding driven by the decoder
//   pc_state_t : sequencer states
//   PW_DEFAULT : default program-counter width (2**PW instruction words)
//   CW_DEFAULT : default cycle-counter width
//   OFFSET_W   : width of the signed relative branch offset
package pc_flag_unit_pkg;

    localparam int PW_DEFAULT = 10;
    localparam int CW_DEFAULT = 16;
    localparam int OFFSET_W   = 8;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_EQ     = 2'b01,   // taken when Z
        COND_NE     = 2'b10,   // taken when !Z
        COND_LT     = 2'b11    // taken when N
    } cond_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } pc_state_t;

endpackage

// File: rtl/pc_flag_unit_if.sv
// Bus between the decoder/ALU/harness side and the PC/flag stage.
//   master : decoder/harness side, drives control + ALU flags, reads PC/status
//   slave  : pc_flag_unit side
// Signals:
//   start, stall, flag_we, zero_in, neg_in, branch, cond, br_rel, offset,
//   abs_target, halt_req                       (master -> slave)
//   prog_ctr, zero_flag, neg_flag, branch_taken, done, cycle_ct (slave -> master)
interface pc_flag_unit_if
    import pc_flag_unit_pkg::*;
#(
    parameter int PW = PW_DEFAULT,
    parameter int CW = CW_DEFAULT
);

    logic                start;
    logic                stall;
    logic                flag_we;
    logic                zero_in;
    logic                neg_in;
    logic                branch;
    cond_t               cond;
    logic                br_rel;
    logic [OFFSET_W-1:0] offset;
    logic [PW-1:0]       abs_target;
    logic                halt_req;

    logic [PW-1:0]       prog_ctr;
    logic                zero_flag;
    logic                neg_flag;
    logic                branch_taken;
    logic                done;
    logic [CW-1:0]       cycle_ct;

    modport master (
        output start, stall, flag_we, zero_in, neg_in, branch, cond,
               br_rel, offset, abs_target, halt_req,
        input  prog_ctr, zero_flag, neg_flag, branch_taken, done, cycle_ct
    );

    modport slave (
        input  start, stall, flag_we, zero_in, neg_in, branch, cond,
               br_rel, offset, abs_target, halt_req,
        output prog_ctr, zero_flag, neg_flag, branch_taken, done, cycle_ct
    );

endinterface

// File: rtl/pc_flag_unit_branch_cond_eval.sv
// Combinational branch-condition evaluator.
//   cond : condition code (ALWAYS/EQ/NE/LT)
//   z    : zero flag to test
//   n    : negative flag to test
//   take : condition satisfied
// Kept stand-alone so the decoder's assertions can reuse the same decode.
module branch_cond_eval
    import pc_flag_unit_pkg::*;
(
    input  cond_t cond,
    input  logic  z,
    input  logic  n,
    output logic  take
);

    always_comb begin
        // NOTE: default first so every path assigns take; no latch is inferred.
        take = 1'b0;
        unique case (cond)
            COND_ALWAYS: take = 1'b1;
            COND_EQ:     take = z;
            COND_NE:     take = !z;
            COND_LT:     take = n;
            default:     take = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_flag_unit.sv
// Program-counter and condition-flag stage downstream of the ALU.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pc_flag_unit_if.slave (control in, PC/flags/status out)
// Behaviour: IDLE -> RUN on start, RUN -> HALT on an unstalled halt_req,
// HALT -> RUN on start (clearing PC, flags and cycle count). In RUN the PC
// advances by one or to a resolved branch target; branches always test the
// registered flags, so a flag-setting branch sees the previous flags.
module pc_flag_unit
    import pc_flag_unit_pkg::*;
#(
    parameter int PW = PW_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_flag_unit_if.slave  bus
);

    pc_state_t      state_q, state_d;
    logic [PW-1:0]  pc_q,    pc_d;
    logic           zero_q,  zero_d;
    logic           neg_q,   neg_d;
    logic [CW-1:0]  cyc_q,   cyc_d;
    logic           done_q,  done_d;

    logic           cond_ok;
    logic           taken;
    logic [PW-1:0]  target;
    logic [PW-1:0]  pc_inc;
    logic           active;   // RUN and not stalled

    branch_cond_eval u_cond (
        .cond (bus.cond),
        .z    (zero_q),
        .n    (neg_q),
        .take (cond_ok)
    );

    always_comb begin
        active = (state_q == RUN) && !bus.stall;
        taken  = bus.branch && active && cond_ok;
        pc_inc = pc_q + PW'(1);
        // Signed cast sign-extends the offset; the PW-bit sum wraps modulo 2**PW.
        target = bus.br_rel ? (pc_q + PW'(signed'(bus.offset))) : bus.abs_target;

        state_d = state_q;
        pc_d    = pc_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        cyc_d   = cyc_q;

        unique case (state_q)
            IDLE, HALT: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    zero_d  = 1'b0;
                    neg_d   = 1'b0;
                    cyc_d   = '0;
                end
            end
            RUN: begin
                if (active) begin
                    cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + CW'(1);
                    if (bus.flag_we) begin
                        zero_d = bus.zero_in;
                        neg_d  = bus.neg_in;
                    end
                    // Halt takes priority over a branch in the same cycle.
                    if (bus.halt_req) begin
                        state_d = HALT;
                    end else begin
                        pc_d = taken ? target : pc_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        done_d = (state_d == HALT);
    end

    // NOTE: async reset clears every flop; state must not survive a reset mid-RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            cyc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so all flops sample pre-edge values together.
            state_q <= state_d;
            pc_q    <= pc_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            cyc_q   <= cyc_d;
            done_q  <= done_d;
        end
    end

    assign bus.prog_ctr     = pc_q;
    assign bus.zero_flag    = zero_q;
    assign bus.neg_flag     = neg_q;
    assign bus.branch_taken = taken;
    assign bus.done         = done_q;
    assign bus.cycle_ct     = cyc_q;

endmodule
